// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the load/store stage and the data memory.
// master: the load/store unit (drives request, write enable, address, write data).
// slave:  the data memory (drives completion and read data).
interface mem_access_unit_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              dm_req;
    logic              dm_we;
    logic [DATA_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_ack,
        input  dm_rdata
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_ack,
        output dm_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store stage sitting directly after the ALU. Runs one data-memory transaction per accepted
// enable_mem over a req/ack handshake, returns load data to writeback and flags address faults
// and memory timeouts.
// Build option: define MAU_ALIGN_CHECK_EN to fault on word-misaligned addresses (code 01).
// Without it, the low two address bits are simply dropped.
module mem_access_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable_mem,
    input  logic                      is_load,
    input  logic                      is_store,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_overflow,
    input  logic [DATA_W-1:0]         store_data,
    mem_access_unit_if.master         dm,
    output logic [DATA_W-1:0]         load_data,
    output logic                      mem_done,
    output logic                      load_valid,
    output logic                      mem_busy,
    output logic                      mem_fault,
    output logic [1:0]                fault_code
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone,
        StFault
    } state_e;

    localparam logic [1:0] FaultIllegal  = 2'b00;
    localparam logic [1:0] FaultMisalign = 2'b01;
    localparam logic [1:0] FaultOverflow = 2'b10;
    localparam logic [1:0] FaultTimeout  = 2'b11;

    // Last REQ cycle allowed to wait for dm_ack.
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT - 1);

    // Word-aligned view of the effective address.
    localparam logic [DATA_W-1:0] AddrMask = {{(DATA_W - 2){1'b1}}, 2'b00};

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic [1:0]          fault_code_q, fault_code_d;
    logic                misaligned;

`ifdef MAU_ALIGN_CHECK_EN
    assign misaligned = (alu_result[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // State and datapath registers; reset clears everything, dropping dm_req immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            load_data_q  <= '0;
            fault_code_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Next-state logic: accept/classify in IDLE, wait for ack or timeout in REQ.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        fault_code_d = fault_code_q;

        unique case (state_q)
            StIdle: begin
                // enable_mem with no access type is not an instruction for us.
                if (enable_mem && (is_load || is_store)) begin
                    if (is_load && is_store) begin
                        fault_code_d = FaultIllegal;
                        state_d      = StFault;
                    end else if (alu_overflow) begin
                        fault_code_d = FaultOverflow;
                        state_d      = StFault;
                    end else if (misaligned) begin
                        fault_code_d = FaultMisalign;
                        state_d      = StFault;
                    end else begin
                        addr_d  = alu_result & AddrMask;
                        wdata_d = store_data;
                        we_d    = is_store;
                        cnt_d   = '0;
                        state_d = StReq;
                    end
                end
            end

            StReq: begin
                if (dm.dm_ack) begin
                    // A read is the only case that updates the load result.
                    if (!we_q) begin
                        load_data_d = dm.dm_rdata;
                    end
                    state_d = StDone;
                end else if (cnt_q == CntMax) begin
                    fault_code_d = FaultTimeout;
                    state_d      = StFault;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            StFault: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state; bus fields read as zero outside REQ.
    always_comb begin
        dm.dm_req   = (state_q == StReq);
        dm.dm_we    = dm.dm_req ? we_q : 1'b0;
        dm.dm_addr  = dm.dm_req ? addr_q : '0;
        dm.dm_wdata = dm.dm_req ? wdata_q : '0;
        mem_done    = (state_q == StDone);
        load_valid  = mem_done && !we_q;
        mem_busy    = (state_q != StIdle);
        mem_fault   = (state_q == StFault);
        fault_code  = mem_fault ? fault_code_q : 2'b00;
        load_data   = load_data_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, address faults, timeout and async reset.
module tb_mem_access_unit;

    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              enable_mem;
    logic              is_load;
    logic              is_store;
    logic [DATA_W-1:0] alu_result;
    logic              alu_overflow;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] load_data;
    logic              mem_done;
    logic              load_valid;
    logic              mem_busy;
    logic              mem_fault;
    logic [1:0]        fault_code;

    int n_checks;
    int n_pass;
    int req_cycles;

    mem_access_unit_if #(.DATA_W(DATA_W)) bus ();

    mem_access_unit #(
        .DATA_W (DATA_W),
        .TIMEOUT(15),
        .CNT_W  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_mem  (enable_mem),
        .is_load     (is_load),
        .is_store    (is_store),
        .alu_result  (alu_result),
        .alu_overflow(alu_overflow),
        .store_data  (store_data),
        .dm          (bus.master),
        .load_data   (load_data),
        .mem_done    (mem_done),
        .load_valid  (load_valid),
        .mem_busy    (mem_busy),
        .mem_fault   (mem_fault),
        .fault_code  (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pulse enable_mem for one cycle; returns at the negedge after the accepting edge.
    task automatic issue(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] data, input logic ovf);
        enable_mem   = 1'b1;
        is_load      = ld;
        is_store     = st;
        alu_result   = addr;
        store_data   = data;
        alu_overflow = ovf;
        @(negedge clk);
        enable_mem   = 1'b0;
        is_load      = 1'b0;
        is_store     = 1'b0;
        alu_overflow = 1'b0;
    endtask

    // Count dm_req cycles, acking in request cycle ack_after+1 (negative: never). Bounded.
    task automatic run_req(input int ack_after, input logic [31:0] rdata, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.dm_req) break;
            n++;
            if (n == ack_after + 1) begin
                bus.dm_ack   = 1'b1;
                bus.dm_rdata = rdata;
            end else begin
                bus.dm_ack   = 1'b0;
                bus.dm_rdata = 32'h0;
            end
            @(negedge clk);
        end
        bus.dm_ack   = 1'b0;
        bus.dm_rdata = 32'h0;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b0;
        enable_mem   = 1'b0;
        is_load      = 1'b0;
        is_store     = 1'b0;
        alu_result   = '0;
        alu_overflow = 1'b0;
        store_data   = '0;
        bus.dm_ack   = 1'b0;
        bus.dm_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req", {31'b0, bus.dm_req}, 32'h0);
        check("rst_busy", {31'b0, mem_busy}, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_fault", {29'b0, mem_fault, fault_code}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // 1: load 0x100, ack two cycles after request
        issue(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
        check("t1_req", {31'b0, bus.dm_req}, 32'h1);
        check("t1_we", {31'b0, bus.dm_we}, 32'h0);
        check("t1_addr", bus.dm_addr, 32'h100);
        check("t1_busy", {31'b0, mem_busy}, 32'h1);
        run_req(2, 32'hDEAD_BEEF, req_cycles);
        check("t1_req_cycles", req_cycles, 32'd3);
        check("t1_done", {30'b0, mem_done, load_valid}, 32'h3);
        check("t1_load_data", load_data, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t1_idle", {30'b0, mem_busy, mem_done}, 32'h0);

        // 2: store 0x40, ack in the first request cycle
        issue(1'b0, 1'b1, 32'h40, 32'h1234_5678, 1'b0);
        check("t2_we", {31'b0, bus.dm_we}, 32'h1);
        check("t2_wdata", bus.dm_wdata, 32'h1234_5678);
        check("t2_addr", bus.dm_addr, 32'h40);
        run_req(0, 32'h0, req_cycles);
        check("t2_req_cycles", req_cycles, 32'd1);
        check("t2_done", {30'b0, mem_done, load_valid}, 32'h2);
        check("t2_load_data_kept", load_data, 32'hDEAD_BEEF);
        check("t2_wdata_zero", bus.dm_wdata, 32'h0);
        @(negedge clk);

        // 3: misaligned load 0x102
        issue(1'b1, 1'b0, 32'h102, 32'h0, 1'b0);
`ifdef MAU_ALIGN_CHECK_EN
        check("t3_no_req", {31'b0, bus.dm_req}, 32'h0);
        check("t3_fault", {29'b0, mem_fault, fault_code}, 32'h5);
        @(negedge clk);
`else
        check("t3_req", {31'b0, bus.dm_req}, 32'h1);
        check("t3_addr", bus.dm_addr, 32'h100);
        run_req(0, 32'h0BAD_F00D, req_cycles);
        check("t3_done", {30'b0, mem_done, load_valid}, 32'h3);
        check("t3_load_data", load_data, 32'h0BAD_F00D);
        @(negedge clk);
`endif

        // 4: overflow outranks misalignment; load+store is illegal
        issue(1'b1, 1'b0, 32'h103, 32'h0, 1'b1);
        check("t4_ovf_no_req", {31'b0, bus.dm_req}, 32'h0);
        check("t4_ovf_fault", {29'b0, mem_fault, fault_code}, 32'h6);
        @(negedge clk);
        check("t4_ovf_idle", {30'b0, mem_busy, mem_fault}, 32'h0);
        issue(1'b1, 1'b1, 32'h80, 32'h0, 1'b0);
        check("t4_ill_fault", {29'b0, mem_fault, fault_code}, 32'h4);
        @(negedge clk);
        issue(1'b0, 1'b0, 32'h80, 32'h0, 1'b0);
        check("t4_noop_idle", {31'b0, mem_busy}, 32'h0);

        // enable_mem during REQ is ignored
        issue(1'b1, 1'b0, 32'h200, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 32'h300, 32'h5555_AAAA, 1'b0);
        check("ign_addr", bus.dm_addr, 32'h200);
        check("ign_we", {31'b0, bus.dm_we}, 32'h0);
        run_req(0, 32'hCAFE_F00D, req_cycles);
        check("ign_load_data", load_data, 32'hCAFE_F00D);
        @(negedge clk);
        check("ign_idle", {31'b0, mem_busy}, 32'h0);

        // 5: store with no ack times out after exactly 15 request cycles
        issue(1'b0, 1'b1, 32'h80, 32'hA5A5_A5A5, 1'b0);
        check("t5_wdata", bus.dm_wdata, 32'hA5A5_A5A5);
        run_req(-1, 32'h0, req_cycles);
        check("t5_req_cycles", req_cycles, 32'd15);
        check("t5_fault", {29'b0, mem_fault, fault_code}, 32'h7);
        check("t5_no_done", {31'b0, mem_done}, 32'h0);
        check("t5_load_data_kept", load_data, 32'hCAFE_F00D);
        @(negedge clk);
        check("t5_idle", {31'b0, mem_busy}, 32'h0);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        check("t5_next_accepted", {31'b0, bus.dm_req}, 32'h1);
        run_req(1, 32'h0000_0042, req_cycles);
        check("t5_next_done", {30'b0, mem_done, load_valid}, 32'h3);
        @(negedge clk);

        // 6: asynchronous reset mid-REQ, then a stale ack after release
        issue(1'b0, 1'b1, 32'h20, 32'h7777_0000, 1'b0);
        check("t6_req_before", {31'b0, bus.dm_req}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("t6_req_async", {31'b0, bus.dm_req}, 32'h0);
        check("t6_busy_async", {31'b0, mem_busy}, 32'h0);
        check("t6_addr_async", bus.dm_addr, 32'h0);
        check("t6_load_data_clr", load_data, 32'h0);
        @(negedge clk);
        reset        = 1'b1;
        bus.dm_ack   = 1'b1;
        bus.dm_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("t6_stale_ack", {30'b0, mem_done, mem_busy}, 32'h0);
        bus.dm_ack = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
